// File: rtl/stores.sv
// Store-side half-word streamer: accepts one 32-bit word plus a store opcode and
// emits the selected 16-bit half or halves over a valid/ready output bus.
module stores #(
  parameter int HALF_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          opcode,
  input  logic [2*HALF_W-1:0] rs,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [HALF_W-1:0]   out_data,
  output logic                out_last,
  output logic                op_err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SEND_HI = 2'd1;
  localparam logic [1:0] SEND_LO = 2'd2;

  localparam logic [1:0] OP_SUH  = 2'b00;
  localparam logic [1:0] OP_SLH  = 2'b01;
  localparam logic [1:0] OP_SW   = 2'b10;

  logic [1:0]          state_q, state_d;
  logic [2*HALF_W-1:0] word_q,  word_d;
  logic [1:0]          op_q,    op_d;
  logic                err_q,   err_d;
  logic                accept;

  // in_ready is gated by rst so nothing is accepted while reset is held low.
  assign in_ready  = (state_q == IDLE) && rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q != IDLE);
  assign op_err    = err_q;

  always_comb begin
    out_data = '0;
    out_last = 1'b0;
    case (state_q)
      SEND_HI: begin
        out_data = word_q[2*HALF_W-1:HALF_W];
        out_last = (op_q != OP_SW);
      end
      SEND_LO: begin
        out_data = word_q[HALF_W-1:0];
        out_last = 1'b1;
      end
      default: begin
        out_data = '0;
        out_last = 1'b0;
      end
    endcase
  end

  // Reserved opcodes are latched like any other but never leave IDLE.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    op_d    = op_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          word_d = rs;
          op_d   = opcode;
          case (opcode)
            OP_SUH:  state_d = SEND_HI;
            OP_SW:   state_d = SEND_HI;
            OP_SLH:  state_d = SEND_LO;
            default: err_d   = 1'b1;
          endcase
        end
      end
      SEND_HI: begin
        if (out_ready) begin
          state_d = (op_q == OP_SW) ? SEND_LO : IDLE;
        end
      end
      SEND_LO: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      op_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_stores.sv
// Bench for stores: a vector table of store requests whose expected beats go through a
// scoreboard queue, plus hand-written stall, back-pressure and reset sequences.
module tb_stores;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  opcode = 2'b00;
  logic [31:0] rs = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_last;
  logic        op_err;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [15:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs;
    int          stall;
    int          nBeats;
    logic [15:0] beat0;
    logic        last0;
    logic [15:0] beat1;
    logic        expErr;
  } vec_t;

  beat_t sbQ[$];
  vec_t  vecs[8];

  stores #(.HALF_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .rs        (rs),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .op_err    (op_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, then lets the request be taken on the next edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] word);
    int budget = 10;
    opcode   = op;
    rs       = word;
    in_valid = 1'b1;
    while (!in_ready && budget > 0) begin
      tick();
      budget--;
    end
    checkOutput("acceptTimeout", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Consumes every queued beat; the first beat is back-pressured for 'stall' cycles.
  task automatic drainBeats(input int stall);
    int budget = 20;
    int held = 0;
    while (sbQ.size() > 0 && budget > 0) begin
      out_ready = (held >= stall);
      checkOutput("beatValid", {31'd0, out_valid}, 32'd1);
      checkOutput("beatData",  {16'd0, out_data}, {16'd0, sbQ[0].data});
      checkOutput("beatLast",  {31'd0, out_last}, {31'd0, sbQ[0].last});
      checkOutput("busyInReady", {31'd0, in_ready}, 32'd0);
      if (out_ready) void'(sbQ.pop_front());
      else held++;
      tick();
      budget--;
    end
    checkOutput("drainTimeout", sbQ.size(), 32'd0);
    sbQ.delete();
    out_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{2'b10, 32'hDEADBEEF, 0, 2, 16'hDEAD, 1'b0, 16'hBEEF, 1'b0};
    vecs[1] = '{2'b00, 32'h12345678, 0, 1, 16'h1234, 1'b1, 16'h0000, 1'b0};
    vecs[2] = '{2'b01, 32'h12345678, 0, 1, 16'h5678, 1'b1, 16'h0000, 1'b0};
    vecs[3] = '{2'b10, 32'hCAFEF00D, 3, 2, 16'hCAFE, 1'b0, 16'hF00D, 1'b0};
    vecs[4] = '{2'b00, 32'hFFFF0000, 1, 1, 16'hFFFF, 1'b1, 16'h0000, 1'b0};
    vecs[5] = '{2'b01, 32'h0000FFFF, 2, 1, 16'hFFFF, 1'b1, 16'h0000, 1'b0};
    vecs[6] = '{2'b11, 32'h55AA55AA, 0, 0, 16'h0000, 1'b0, 16'h0000, 1'b1};
    vecs[7] = '{2'b10, 32'h80000001, 1, 2, 16'h8000, 1'b0, 16'h0001, 1'b0};

    #12;
    checkOutput("rstInReady",  {31'd0, in_ready},  32'd0);
    checkOutput("rstOutValid", {31'd0, out_valid}, 32'd0);
    checkOutput("rstOutData",  {16'd0, out_data},  32'd0);
    checkOutput("rstOutLast",  {31'd0, out_last},  32'd0);
    checkOutput("rstOpErr",    {31'd0, op_err},    32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    checkOutput("idleInReady", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].op, vecs[i].rs);
      if (vecs[i].nBeats >= 1) sbQ.push_back('{vecs[i].beat0, vecs[i].last0});
      if (vecs[i].nBeats == 2) sbQ.push_back('{vecs[i].beat1, 1'b1});
      checkOutput($sformatf("opErr%0d", i), {31'd0, op_err}, {31'd0, vecs[i].expErr});
      if (vecs[i].expErr) begin
        checkOutput("resOutValid", {31'd0, out_valid}, 32'd0);
        checkOutput("resInReady",  {31'd0, in_ready},  32'd1);
        tick();
        checkOutput("resErrPulse", {31'd0, op_err}, 32'd0);
      end
      drainBeats(vecs[i].stall);
      checkOutput($sformatf("endIdle%0d", i), {31'd0, out_valid}, 32'd0);
      checkOutput($sformatf("endReady%0d", i), {31'd0, in_ready}, 32'd1);
      tick();
    end

    // A request held during a transfer must wait, and its new rs must not disturb the word in flight.
    applyStimulus(2'b10, 32'h11112222);
    in_valid = 1'b1;
    rs       = 32'h00000000;
    opcode   = 2'b10;
    sbQ.push_back('{16'h1111, 1'b0});
    sbQ.push_back('{16'h2222, 1'b1});
    drainBeats(1);
    checkOutput("heldReady", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    sbQ.push_back('{16'h0000, 1'b0});
    sbQ.push_back('{16'h0000, 1'b1});
    drainBeats(0);
    checkOutput("heldDone", {31'd0, out_valid}, 32'd0);
    tick();

    // Reset in SEND_HI drops the word entirely.
    applyStimulus(2'b10, 32'hA5A55A5A);
    checkOutput("preRstValid", {31'd0, out_valid}, 32'd1);
    checkOutput("preRstData",  {16'd0, out_data},  32'h0000A5A5);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midRstValid", {31'd0, out_valid}, 32'd0);
    checkOutput("midRstReady", {31'd0, in_ready},  32'd0);
    checkOutput("midRstData",  {16'd0, out_data},  32'd0);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("postRstValid", {31'd0, out_valid}, 32'd0);
      checkOutput("postRstReady", {31'd0, in_ready},  32'd1);
    end
    out_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL globalTimeout: got hang, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
